// File: rtl/vout_timing_gen.sv
// vout_timing_gen: display-side raster timing generator.
// Drives the frame buffer read side (rd_fsync / rd_en), takes the returned
// pixel stream back and emits latency-aligned hs/vs/de/rgb to the encoder.
// Reads are held off until init_done (synchronised) is seen on a frame
// boundary; once running, the block keeps running until reset.
// Optional build macro: TEST_PATTERN_EN adds pattern_sel and an 8-bar
// colour pattern generator that replaces frame buffer pixels.
module vout_timing_gen #(
  parameter int unsigned H_ACT     = 1024,
  parameter int unsigned H_FP      = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BP      = 160,
  parameter int unsigned V_ACT     = 768,
  parameter int unsigned V_FP      = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 29,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned PIX_WIDTH = 16
) (
  input  logic                 vout_clk,
  input  logic                 rstn,
  input  logic                 init_done,
`ifdef TEST_PATTERN_EN
  input  logic                 pattern_sel,
`endif
  output logic                 rd_fsync,
  output logic                 rd_en,
  input  logic                 vout_de,
  input  logic [PIX_WIDTH-1:0] vout_data,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 de_out,
  output logic [PIX_WIDTH-1:0] rgb_out,
  output logic                 underflow
);

  localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
  localparam logic [11:0] H_SYNC_C = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_C = 12'(V_SYNC);
  localparam logic [11:0] H_A0     = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_A1     = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] V_A0     = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_A1     = 12'(V_SYNC + V_BP + V_ACT);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        init_meta_q, init_s_q;
  logic        run_q;
  logic        frame_start, run_set;
  logic        hs_raw, vs_raw, act_raw, stage_de;
  logic        rd_fsync_q, rd_fsync_d;
  logic        rd_en_q, rd_en_d;
  logic        pat_on;

  // Index 0 is aligned with rd_en, index RD_LAT with the returned vout_de.
  logic [RD_LAT:0] hs_pipe_q, vs_pipe_q, de_pipe_q;
  logic            hs_tail, vs_tail, de_tail, pix_expected;

  logic                 hs_out_q, vs_out_q, de_out_q, underflow_q;
  logic [PIX_WIDTH-1:0] rgb_out_q, rgb_d;

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACT / 8;

  logic [11:0]           x_off;
  logic [2:0]            bar_d, bar_tail;
  logic [RD_LAT:0][2:0]  bar_pipe_q;

  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  assign pat_on   = pattern_sel;
  assign x_off    = h_cnt_q - H_A0;
  assign bar_d    = 3'(x_off / 12'(BAR_W));
  assign bar_tail = bar_pipe_q[RD_LAT];
`else
  assign pat_on = 1'b0;
`endif

  // Next-state of the free-running raster counters.
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
    end
  end

  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign run_set     = frame_start && init_s_q;
  assign hs_raw      = h_cnt_q < H_SYNC_C;
  assign vs_raw      = v_cnt_q < V_SYNC_C;
  assign act_raw     = (h_cnt_q >= H_A0) && (h_cnt_q < H_A1) &&
                       (v_cnt_q >= V_A0) && (v_cnt_q < V_A1);

  assign rd_fsync_d  = frame_start && (run_q || init_s_q) && !pat_on;
  assign rd_en_d     = act_raw && run_q && !pat_on;
  assign stage_de    = act_raw && (run_q || pat_on);

  assign hs_tail      = hs_pipe_q[RD_LAT];
  assign vs_tail      = vs_pipe_q[RD_LAT];
  assign de_tail      = de_pipe_q[RD_LAT];
  assign pix_expected = de_tail && !pat_on;

  // Pixel selection for the output register: returned pixel or zero.
  always_comb begin
    rgb_d = '0;
    if (pix_expected && vout_de) rgb_d = vout_data;
`ifdef TEST_PATTERN_EN
    if (pat_on && de_tail) rgb_d = PIX_WIDTH'(bar_colour(bar_tail));
`endif
  end

  // Counters, init_done synchroniser, run flag and frame buffer strobes.
  always_ff @(posedge vout_clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      init_meta_q <= 1'b0;
      init_s_q    <= 1'b0;
      run_q       <= 1'b0;
      rd_fsync_q  <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      init_meta_q <= init_done;
      init_s_q    <= init_meta_q;
      run_q       <= run_q || run_set;
      rd_fsync_q  <= rd_fsync_d;
      rd_en_q     <= rd_en_d;
    end
  end

  // Timing delay line covering the frame buffer read latency.
  always_ff @(posedge vout_clk or negedge rstn) begin
    if (!rstn) begin
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      de_pipe_q <= '0;
    end else begin
      hs_pipe_q <= {hs_pipe_q[RD_LAT-1:0], hs_raw};
      vs_pipe_q <= {vs_pipe_q[RD_LAT-1:0], vs_raw};
      de_pipe_q <= {de_pipe_q[RD_LAT-1:0], stage_de};
    end
  end

`ifdef TEST_PATTERN_EN
  // Bar index travels with the timing so colours line up with de_out.
  always_ff @(posedge vout_clk or negedge rstn) begin
    if (!rstn) bar_pipe_q <= '0;
    else       bar_pipe_q <= {bar_pipe_q[RD_LAT-1:0], bar_d};
  end
`endif

  // Encoder-facing output registers and sticky underflow flag.
  always_ff @(posedge vout_clk or negedge rstn) begin
    if (!rstn) begin
      hs_out_q    <= ~HS_POL;
      vs_out_q    <= ~VS_POL;
      de_out_q    <= 1'b0;
      rgb_out_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      hs_out_q    <= hs_tail ? HS_POL : ~HS_POL;
      vs_out_q    <= vs_tail ? VS_POL : ~VS_POL;
      de_out_q    <= de_tail;
      rgb_out_q   <= rgb_d;
      underflow_q <= underflow_q || (pix_expected && !vout_de);
    end
  end

  assign rd_fsync  = rd_fsync_q;
  assign rd_en     = rd_en_q;
  assign hs_out    = hs_out_q;
  assign vs_out    = vs_out_q;
  assign de_out    = de_out_q;
  assign rgb_out   = rgb_out_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vout_timing_gen.sv
// Bench for vout_timing_gen with a reduced raster so several frames fit in a
// short run. Expected outputs come from a cycle-indexed raster model; the
// frame buffer is emulated from the model's own read schedule.
module tb_vout_timing_gen;

  localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 4;
  localparam int V_ACT = 6,  V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int RD_LAT = 2;
  localparam int PW = 16;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int MAXC = 4096;

  logic          clk, rstn, init_done, vout_de;
  logic [PW-1:0] vout_data, rgb_out;
  logic          rd_fsync, rd_en, hs_out, vs_out, de_out, underflow;

  vout_timing_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .RD_LAT(RD_LAT), .PIX_WIDTH(PW)
  ) dut (
    .vout_clk(clk), .rstn(rstn), .init_done(init_done),
`ifdef TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .rd_fsync(rd_fsync), .rd_en(rd_en), .vout_de(vout_de), .vout_data(vout_data),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .rgb_out(rgb_out),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;             // edges since reset release; cycle k follows edge k
  int run_start = -1;    // cycle whose frame start launched reads
  bit uf_m = 1'b0;
  bit init_lvl = 1'b0;
  bit drop_once = 1'b0;
  int drop_pct = 0;

  bit          init_drv [MAXC];
  bit          drv_de   [MAXC];
  logic [15:0] drv_data [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, k);
    end
  endtask

  function automatic int hpos(int j); return (j % FRAME) % H_TOT; endfunction
  function automatic int vpos(int j); return (j % FRAME) / H_TOT; endfunction

  function automatic bit act_f(int j);
    return hpos(j) >= H_SYNC + H_BP && hpos(j) < H_SYNC + H_BP + H_ACT &&
           vpos(j) >= V_SYNC + V_BP && vpos(j) < V_SYNC + V_BP + V_ACT;
  endfunction

  function automatic bit run_f(int j);
    return run_start >= 0 && j > run_start;
  endfunction

  // rd_en as seen in cycle c
  function automatic bit exp_rd_f(int c);
    return c >= 1 && act_f(c - 1) && run_f(c - 1);
  endfunction

  task automatic step();
    bit   e_fs, e_rd, e_de, e_hs, e_vs, exp_pix, de;
    logic [15:0] e_rgb, d;
    int   m;
    @(posedge clk);
    k++;
    @(negedge clk);
    if (run_start < 0 && k >= 2 && init_drv[k-2] && (k % FRAME) == 0) run_start = k;
    e_fs  = ((k - 1) % FRAME) == 0 && run_start >= 0 && (k - 1) >= run_start;
    e_rd  = exp_rd_f(k);
    m     = k - 2 - RD_LAT;
    e_de  = m >= 0 && act_f(m) && run_f(m);
    e_hs  = (m >= 0 && hpos(m) < H_SYNC) ? HS_POL : !HS_POL;
    e_vs  = (m >= 0 && vpos(m) < V_SYNC) ? VS_POL : !VS_POL;
    e_rgb = (e_de && drv_de[k-1]) ? drv_data[k-1] : 16'h0;
    if (e_de && !drv_de[k-1]) uf_m = 1'b1;
    check_eq("rd_fsync",  32'(rd_fsync),  32'(e_fs));
    check_eq("rd_en",     32'(rd_en),     32'(e_rd));
    check_eq("de_out",    32'(de_out),    32'(e_de));
    check_eq("hs_out",    32'(hs_out),    32'(e_hs));
    check_eq("vs_out",    32'(vs_out),    32'(e_vs));
    check_eq("rgb_out",   32'(rgb_out),   32'(e_rgb));
    check_eq("underflow", 32'(underflow), 32'(uf_m));
    // drive inputs for cycle k
    init_done   = init_lvl;
    init_drv[k] = init_lvl;
    exp_pix = exp_rd_f(k - RD_LAT);
    if (exp_pix) begin
      de = 1'b1;
      if (drop_once) begin
        de = 1'b0;
        drop_once = 1'b0;
      end else if ($urandom_range(0, 99) < drop_pct) de = 1'b0;
    end else begin
      de = ($urandom_range(0, 7) == 0);
    end
    d = 16'($urandom);
    vout_de = de;
    vout_data = d;
    drv_de[k] = de;
    drv_data[k] = d;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rd_en"},    32'(rd_en),     32'(0));
    check_eq({tag, "_rd_fsync"}, 32'(rd_fsync),  32'(0));
    check_eq({tag, "_de_out"},   32'(de_out),    32'(0));
    check_eq({tag, "_rgb_out"},  32'(rgb_out),   32'(0));
    check_eq({tag, "_underflow"},32'(underflow), 32'(0));
    check_eq({tag, "_hs_out"},   32'(hs_out),    32'(!HS_POL));
    check_eq({tag, "_vs_out"},   32'(vs_out),    32'(!VS_POL));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    vout_de = 1'b0;
    #1;
    check_reset_vals("rst_async");
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_reset_vals("rst_hold");
    end
    rstn = 1'b1;
    k = 0;
    run_start = -1;
    uf_m = 1'b0;
    init_done = init_lvl;
    init_drv[0] = init_lvl;
    vout_de = 1'b0;
    vout_data = 16'($urandom);
    drv_de[0] = 1'b0;
    drv_data[0] = vout_data;
  endtask

  initial begin
    int target;
    clk = 1'b0; rstn = 1'b0; init_done = 1'b0; vout_de = 1'b0; vout_data = '0;
    do_reset(3);
    // three frames without init_done, then raise it mid-frame
    repeat (3 * FRAME + $urandom_range(30, FRAME - 30)) step();
    init_lvl = 1'b1;
    repeat (2 * FRAME) step();
    // a later init_done drop must not stop reads
    init_lvl = 1'b0;
    repeat (FRAME / 2) step();
    init_lvl = 1'b1;
    // missing pixels: one forced, plus occasional random ones
    drop_once = 1'b1;
    drop_pct = 3;
    repeat (2 * FRAME) step();
    drop_pct = 0;
    // reset in the middle of an active line
    target = (V_SYNC + V_BP + 3) * H_TOT + H_SYNC + H_BP + 5;
    for (int i = 0; i < FRAME && (k % FRAME) != target; i++) step();
    check_eq("mid_line_reads_active", 32'(rd_en), 32'(1));
    do_reset(5);
    repeat (4 * FRAME) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
